// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter and sequencer for the 4096x16 main memory.
// Serves one latched request at a time: IDLE -> ACCESS -> DONE -> IDLE.
module mem_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 16,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_out,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e        state_q;
  logic          last_b_q;
  logic          gnt_b_q;
  logic          a_ack_q;
  logic          b_ack_q;
  logic [DW-1:0] a_rdata_q;
  logic [DW-1:0] b_rdata_q;
  logic          mem_write_q;
  logic          mem_read_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_data_q;
  logic          busy_q;

  logic          req_d;
  logic          pick_b_d;
  logic          we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;

  // On a tie, B wins only in round-robin mode when A was served last.
  always_comb begin
    req_d    = a_req | b_req;
    pick_b_d = b_req & (~a_req | (~FIXED_PRI & ~last_b_q));
    we_d     = pick_b_d ? b_we    : a_we;
    addr_d   = pick_b_d ? b_addr  : a_addr;
    wdata_d  = pick_b_d ? b_wdata : a_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      gnt_b_q     <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_d) begin
            state_q    <= ACCESS;
            busy_q     <= 1'b1;
            gnt_b_q    <= pick_b_d;
            last_b_q   <= pick_b_d;
            mem_addr_q <= addr_d;
            if (we_d) begin
              mem_data_q  <= wdata_d;
              mem_write_q <= 1'b1;
            end else begin
              mem_read_q  <= 1'b1;
            end
          end
        end
        ACCESS: begin
          state_q     <= DONE;
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b0;
          a_ack_q     <= ~gnt_b_q;
          b_ack_q     <= gnt_b_q;
          if (mem_read_q && !gnt_b_q) a_rdata_q <= mem_out;
          if (mem_read_q &&  gnt_b_q) b_rdata_q <= mem_out;
        end
        DONE: begin
          state_q <= IDLE;
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign mem_write = mem_write_q;
  assign mem_read  = mem_read_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with a transaction-level reference model.
// Inputs change on negedge; outputs are compared on every negedge.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [11:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack, mem_write, mem_read, busy;
  logic [15:0] a_rdata, b_rdata, mem_data;
  logic [11:0] mem_addr;
  logic [15:0] mem_out = '0;

  logic        fp_a_ack, fp_b_ack, fp_mem_write, fp_mem_read, fp_busy;
  logic [15:0] fp_a_rdata, fp_b_rdata, fp_mem_data;
  logic [11:0] fp_mem_addr;
  logic [15:0] fp_mem_out;
  assign fp_mem_out = '0;

  always #5 clock = ~clock;

  mem_arbiter #(.AW(12), .DW(16), .FIXED_PRI(1'b0)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_out(mem_out), .busy(busy)
  );

  mem_arbiter #(.AW(12), .DW(16), .FIXED_PRI(1'b1)) dut_fp (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(fp_a_ack), .a_rdata(fp_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(fp_b_ack), .b_rdata(fp_b_rdata),
    .mem_write(fp_mem_write), .mem_read(fp_mem_read),
    .mem_addr(fp_mem_addr), .mem_data(fp_mem_data),
    .mem_out(fp_mem_out), .busy(fp_busy)
  );

  // Main memory: commits writes on posedge, fetches on a read edge.
  logic [15:0] mem [4096] = '{default: 16'h0};
  always @(posedge clock) if (mem_write) mem[mem_addr] <= mem_data;
  always @(posedge mem_read) begin
    #1;
    mem_out = mem[mem_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one granted transaction, timed from its grant edge g.
  logic [15:0] ref_mem [4096] = '{default: 16'h0};
  int          cyc = 0;
  int          g = -100;
  int          free_at = 0;
  bit          gb, gwe;
  bit          last_b = 1'b1;
  logic [11:0] gaddr;
  logic [15:0] gwdata, pend;
  logic [15:0] exp_ar = '0;
  logic [15:0] exp_br = '0;
  bit          grants [$];

  initial forever begin
    @(posedge clock);
    cyc++;
    if (reset) begin
      g = -100;
      exp_ar = '0;
      exp_br = '0;
      last_b = 1'b1;
      free_at = cyc + 1;
    end else begin
      if (cyc == g + 1 && !gwe) begin
        if (gb) exp_br = pend;
        else    exp_ar = pend;
      end
      if (cyc >= free_at && (a_req || b_req)) begin
        if (a_req && b_req) gb = !last_b;
        else                gb = b_req;
        last_b  = gb;
        g       = cyc;
        free_at = cyc + 3;
        gwe     = gb ? b_we    : a_we;
        gaddr   = gb ? b_addr  : a_addr;
        gwdata  = gb ? b_wdata : a_wdata;
        if (gwe) ref_mem[gaddr] = gwdata;
        else     pend = ref_mem[gaddr];
        grants.push_back(gb);
      end
    end
  end

  int low_run = 0, gap_bad = 0, overlap = 0, b_ack_cnt = 0;
  bit seen_rd = 1'b0;

  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      chk("busy",      32'(busy),      32'(cyc == g || cyc == g + 1));
      chk("a_ack",     32'(a_ack),     32'(cyc == g + 1 && !gb));
      chk("b_ack",     32'(b_ack),     32'(cyc == g + 1 && gb));
      chk("mem_write", 32'(mem_write), 32'(cyc == g && gwe));
      chk("mem_read",  32'(mem_read),  32'(cyc == g && !gwe));
      chk("a_rdata",   32'(a_rdata),   32'(exp_ar));
      chk("b_rdata",   32'(b_rdata),   32'(exp_br));
      if (cyc == g) begin
        chk("mem_addr", 32'(mem_addr), 32'(gaddr));
        if (gwe) chk("mem_data", 32'(mem_data), 32'(gwdata));
      end
      if (a_ack && b_ack) overlap++;
      if (b_ack) b_ack_cnt++;
      if (mem_read) begin
        if (seen_rd && low_run < 2) gap_bad++;
        seen_rd = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
      end
    end
  end

  // Called at a negedge; returns at the negedge where the ack is seen.
  task automatic acc(input bit port, input bit we, input logic [11:0] addr,
                     input logic [15:0] wd, output logic [15:0] rd,
                     output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    rd = '0;
    if (port) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end
    while (!got && waited < 10) begin
      @(negedge clock);
      waited++;
      if (port ? b_ack : a_ack) begin
        got = 1'b1;
        rd = port ? b_rdata : a_rdata;
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
    if (port) b_req = 1'b0;
    else      a_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [15:0] rd, rd2;
  logic [7:0]  seq, mseq;
  int          w, first, n, fpa, fpb, gi0, bc, gb0;
  bit          a_done, b_done;

  initial begin
    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy",     32'(busy),      32'd0);
    chk("rst_acks",     32'({a_ack, b_ack}), 32'd0);
    chk("rst_strobes",  32'({mem_write, mem_read}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr),  32'd0);
    chk("rst_mem_data", 32'(mem_data),  32'd0);
    chk("rst_rdata",    32'({a_rdata, b_rdata}), 32'd0);
    reset = 1'b0;

    // A writes then reads 0x010
    bc = b_ack_cnt;
    acc(1'b0, 1'b1, 12'h010, 16'h1234, rd, w);
    chk("t1_ack_latency", 32'(w), 32'd2);
    acc(1'b0, 1'b0, 12'h010, 16'h0000, rd, w);
    chk("t1_rdata", 32'(rd), 32'h1234);
    chk("t1_no_b_ack", 32'(b_ack_cnt - bc), 32'd0);

    // simultaneous requests straight after reset
    do_reset();
    first = -1; a_done = 1'b0; b_done = 1'b0;
    a_we = 1'b0; a_addr = 12'h010; b_we = 1'b0; b_addr = 12'h010;
    a_req = 1'b1; b_req = 1'b1;
    for (int i = 0; i < 12 && !(a_done && b_done); i++) begin
      @(negedge clock);
      if (a_ack) begin
        if (first < 0) first = 0;
        a_done = 1'b1; a_req = 1'b0;
      end
      if (b_ack) begin
        if (first < 0) first = 1;
        b_done = 1'b1; b_req = 1'b0;
        chk("t2_b_rdata", 32'(b_rdata), 32'h1234);
      end
    end
    chk("t2_both_served", 32'({a_done, b_done}), 32'd3);
    chk("t2_first_is_A", 32'(first), 32'd0);
    chk("t2_no_overlap", 32'(overlap), 32'd0);

    // both ports hold requests for 8 accesses
    do_reset();
    gi0 = grants.size();
    n = 0; fpa = 0; fpb = 0; seq = '0;
    a_we = 1'b0; a_addr = 12'h010; b_we = 1'b0; b_addr = 12'h011;
    a_req = 1'b1; b_req = 1'b1;
    for (int i = 0; i < 40 && n < 8; i++) begin
      @(negedge clock);
      if (fp_a_ack) fpa++;
      if (fp_b_ack) fpb++;
      if (a_ack || b_ack) begin
        seq[n[2:0]] = b_ack;
        n++;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    mseq = '0;
    for (int i = 0; i < 8; i++)
      if (gi0 + i < grants.size()) mseq[i] = grants[gi0 + i];
    chk("t3_rr_order", 32'(seq), 32'h0000_00aa);
    chk("t3_model_order", 32'(mseq), 32'h0000_00aa);
    chk("t3_fp_a_grants", 32'(fpa), 32'd8);
    chk("t3_fp_b_grants", 32'(fpb), 32'd0);
    chk("t3_no_overlap", 32'(overlap), 32'd0);

    // back-to-back reads
    acc(1'b1, 1'b1, 12'h000, 16'haaaa, rd, w);
    acc(1'b1, 1'b1, 12'h001, 16'h5555, rd, w);
    gb0 = gap_bad;
    acc(1'b0, 1'b0, 12'h000, 16'h0000, rd, w);
    acc(1'b0, 1'b0, 12'h001, 16'h0000, rd2, w);
    chk("t4_rd0", 32'(rd), 32'h0000_aaaa);
    chk("t4_rd1", 32'(rd2), 32'h0000_5555);
    chk("t4_read_gap", 32'(gap_bad - gb0), 32'd0);

    // reset lands on the ACCESS cycle of a B write
    @(negedge clock);
    b_we = 1'b1; b_addr = 12'hfff; b_wdata = 16'hbeef; b_req = 1'b1;
    @(negedge clock);
    chk("t5_in_access", 32'(mem_write), 32'd1);
    reset = 1'b1;
    b_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    chk("t5_no_b_ack", 32'(b_ack), 32'd0);
    chk("t5_not_busy", 32'(busy), 32'd0);
    acc(1'b0, 1'b0, 12'hfff, 16'h0000, rd, w);
    chk("t5_committed", 32'(rd), 32'h0000_beef);

    // address change while busy is ignored
    acc(1'b1, 1'b1, 12'h020, 16'h2020, rd, w);
    acc(1'b1, 1'b1, 12'h030, 16'h3030, rd, w);
    @(negedge clock);
    a_we = 1'b0; a_addr = 12'h020; a_req = 1'b1;
    @(negedge clock);
    chk("t6_addr", 32'(mem_addr), 32'h020);
    a_addr = 12'h030;
    @(negedge clock);
    chk("t6_ack", 32'(a_ack), 32'd1);
    chk("t6_rdata", 32'(a_rdata), 32'h0000_2020);
    a_req = 1'b0;
    repeat (3) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
